sram_dp_pipe: RTL and testbench

Parametrised dual-port successor to the single-port async-read sram.
- Port A: read/write with byte enables.
- Port B: read-only.
- Both ports: registered, configurable-latency read pipeline with a valid strobe.
- Same-cycle A-write/B-read collisions are detected and flagged; out-of-range addresses are trapped.
- Sits between the core's load/store and fetch paths and the on-chip memory array.

---
 rtl/sram_pkg.sv | 25 ++
 rtl/sram_rd_pipe.sv | 45 ++++
 rtl/sram_dp_pipe.sv | 107 ++++++++++
 tb/tb_sram_dp_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants and the byte-lane merge helper for the dual-port SRAM pipeline.
package sram_pkg;

  localparam int unsigned MAX_READ_LATENCY = 4;
  localparam int unsigned MAX_DATA_WIDTH   = 256;
  localparam int unsigned MAX_IDX_W        = $clog2(MAX_DATA_WIDTH);

  // Callers zero-extend their words into MAX_DATA_WIDTH and truncate the result back.
  function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_DATA_WIDTH-1:0] be,
    input int unsigned               byte_width
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (be[MAX_IDX_W'(i / byte_width)]) begin
        merged[MAX_IDX_W'(i)] = new_word[MAX_IDX_W'(i)];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line: READ_LATENCY registered stages; data only advances with its valid.
module sram_rd_pipe #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  for (genvar i = 0; i < READ_LATENCY; i++) begin : g_stage
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  prev_valid;
    logic [DATA_WIDTH-1:0] prev_data;

    if (i == 0) begin : g_first
      assign prev_valid = in_valid;
      assign prev_data  = in_data;
    end else begin : g_next
      assign prev_valid = g_stage[i-1].valid_q;
      assign prev_data  = g_stage[i-1].data_q;
    end

    // Holding data on an invalid slot is what keeps dout stable between responses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= prev_valid;
        if (prev_valid) begin
          data_q <= prev_data;
        end
      end
    end
  end

  assign out_valid = g_stage[READ_LATENCY-1].valid_q;
  assign out_data  = g_stage[READ_LATENCY-1].data_q;

endmodule

// File: rtl/sram_dp_pipe.sv
// Dual-port SRAM: port A read/write with byte enables, port B read-only, pipelined reads.
// Define SRAM_BYPASS_EN for write-first B data on an A/B collision (read-first otherwise).
module sram_dp_pipe
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned MEM_DEPTH    = 65536,
  parameter int unsigned ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             a_req,
  input  logic                             a_we,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]            a_din,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be,
  output logic                             a_rvalid,
  output logic [DATA_WIDTH-1:0]            a_dout,
  input  logic                             b_req,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  output logic                             b_rvalid,
  output logic [DATA_WIDTH-1:0]            b_dout,
  output logic                             collision,
  output logic                             addr_err
);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..%0d", MAX_READ_LATENCY);
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH and at most %0d", MAX_DATA_WIDTH);
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  a_ok, b_ok;
  logic                  a_wr, a_rd, collide;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_merged;
  logic [DATA_WIDTH-1:0] a_rd_data, b_rd_data;
  logic                  collision_q, addr_err_q;

  assign a_ok  = 32'(a_addr) < MEM_DEPTH;
  assign b_ok  = 32'(b_addr) < MEM_DEPTH;
  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  assign a_merged = DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(a_old), MAX_DATA_WIDTH'(a_din),
                                         MAX_DATA_WIDTH'(a_be), BYTE_WIDTH));

  assign a_wr    = a_req & a_we & a_ok;
  assign a_rd    = a_req & ~a_we;
  assign collide = a_wr & b_req & b_ok & (a_addr == b_addr);

  // Out-of-range reads still return a response, with zero data.
  assign a_rd_data = a_ok ? a_old : '0;
`ifdef SRAM_BYPASS_EN
  assign b_rd_data = !b_ok ? '0 : (collide ? a_merged : b_old);
`else
  assign b_rd_data = b_ok ? b_old : '0;
`endif

  always_ff @(posedge clk) begin
    if (a_wr) begin
      mem[a_addr] <= a_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      collision_q <= collide;
      addr_err_q  <= (a_req & ~a_ok) | (b_req & ~b_ok);
    end
  end

  assign collision = collision_q;
  assign addr_err  = addr_err_q;

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_a_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (a_rd),
    .in_data  (a_rd_data),
    .out_valid(a_rvalid),
    .out_data (a_dout)
  );

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_b_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (b_req),
    .in_data  (b_rd_data),
    .out_valid(b_rvalid),
    .out_data (b_dout)
  );

endmodule

// File: tb/tb_sram_dp_pipe.sv
// Scoreboard bench for sram_dp_pipe: directed stimulus queues expected responses and events,
// a negedge monitor pops and checks them against data and arrival cycle.
module tb_sram_dp_pipe;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a_req, a_we, a_rvalid, b_req, b_rvalid, collision, addr_err;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, a_dout, b_dout;
  logic [1:0]    a_be;

  sram_dp_pipe #(
    .DATA_WIDTH  (DW),
    .BYTE_WIDTH  (8),
    .MEM_DEPTH   (DEPTH),
    .READ_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_din    (a_din),
    .a_be     (a_be),
    .a_rvalid (a_rvalid),
    .a_dout   (a_dout),
    .b_req    (b_req),
    .b_addr   (b_addr),
    .b_rvalid (b_rvalid),
    .b_dout   (b_dout),
    .collision(collision),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   qcol[$];
  int   qerr[$];
  exp_t ea, eb;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   err_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of its queue, data and cycle.
  always @(negedge clk) begin
    if (a_rvalid) begin
      if (qa.size() == 0) check("a_rvalid unexpected", 32'(a_rvalid), 32'd0);
      else begin
        ea = qa.pop_front();
        check("a_dout", 32'(a_dout), 32'(ea.data));
        check("a_rvalid cycle", cyc, ea.due);
      end
    end
    if (b_rvalid) begin
      if (qb.size() == 0) check("b_rvalid unexpected", 32'(b_rvalid), 32'd0);
      else begin
        eb = qb.pop_front();
        check("b_dout", 32'(b_dout), 32'(eb.data));
        check("b_rvalid cycle", cyc, eb.due);
      end
    end
    if (collision) begin
      if (qcol.size() == 0) check("collision unexpected", 32'(collision), 32'd0);
      else check("collision cycle", cyc, qcol.pop_front());
    end
    if (addr_err) begin
      if (qerr.size() == 0) check("addr_err unexpected", 32'(addr_err), 32'd0);
      else check("addr_err cycle", cyc, qerr.pop_front());
    end
  end

  task automatic step();
    if (err_pend) qerr.push_back(cyc + 1);
    err_pend = 1'b0;
    @(posedge clk);
    #1;
    a_req = 1'b0;
    a_we  = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic a_wr(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [1:0] be);
    a_req  = 1'b1;
    a_we   = 1'b1;
    a_addr = addr;
    a_din  = d;
    a_be   = be;
    if (int'(addr) >= DEPTH) err_pend = 1'b1;
  endtask

  task automatic a_rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    a_req  = 1'b1;
    a_we   = 1'b0;
    a_addr = addr;
    qa.push_back('{due: cyc + LAT, data: exp});
    if (int'(addr) >= DEPTH) err_pend = 1'b1;
  endtask

  task automatic b_rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    b_req  = 1'b1;
    b_addr = addr;
    qb.push_back('{due: cyc + LAT, data: exp});
    if (int'(addr) >= DEPTH) err_pend = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0; a_be = '0;
    b_req = 1'b0; b_addr = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset a_rvalid", 32'(a_rvalid), 32'd0);
    check("reset b_rvalid", 32'(b_rvalid), 32'd0);
    check("reset collision", 32'(collision), 32'd0);
    check("reset addr_err", 32'(addr_err), 32'd0);
    check("reset a_dout", 32'(a_dout), 32'd0);
    check("reset b_dout", 32'(b_dout), 32'd0);
    rst = 1'b0;
    step();

    // Fill 0..7, then stream them out of port B back-to-back.
    for (int i = 0; i < 8; i++) begin
      a_wr(AW'(i), 16'h1000 + 16'(i), 2'b11);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      b_rd(AW'(i), 16'h1000 + 16'(i));
      step();
    end
    repeat (LAT + 2) step();
    check("b_dout hold", 32'(b_dout), 32'h1007);
    check("b_rvalid idle", 32'(b_rvalid), 32'd0);

    // Out-of-range accesses; 999 is the last legal word.
    a_wr(10'd1000, 16'hDEAD, 2'b11);
    step();
    a_rd(10'd1000, 16'h0000);
    step();
    a_rd(10'd1001, 16'h0000);
    b_rd(10'd1023, 16'h0000);
    step();
    a_wr(10'd999, 16'hBEEF, 2'b11);
    step();
    a_rd(10'd999, 16'hBEEF);
    step();
    for (int i = 0; i < 8; i++) begin
      a_rd(AW'(i), 16'h1000 + 16'(i));
      step();
    end
    b_rd(10'd3, 16'h1003);
    step();
    repeat (LAT + 2) step();

    // Reset one cycle after a B read: the read must vanish, memory must survive.
    b_req  = 1'b1;
    b_addr = 10'd6;
    step();
    rst = 1'b1;
    repeat (LAT + 1) step();
    check("rst b_dout", 32'(b_dout), 32'd0);
    check("rst b_rvalid", 32'(b_rvalid), 32'd0);
    rst = 1'b0;
    step();
    b_rd(10'd6, 16'h1006);
    a_rd(10'd3, 16'h1003);
    step();

    // Write then read-after-write on port A.
    a_wr(10'd5, 16'h1234, 2'b11);
    step();
    a_rd(10'd5, 16'h1234);
    step();

    // Byte enables, including the no-op write.
    a_wr(10'd7, 16'hAABB, 2'b11);
    step();
    a_wr(10'd7, 16'h1122, 2'b01);
    step();
    a_rd(10'd7, 16'hAA22);
    step();
    a_wr(10'd7, 16'hFFFF, 2'b00);
    step();
    a_rd(10'd7, 16'hAA22);
    step();
    a_wr(10'd7, 16'h5500, 2'b10);
    step();
    a_rd(10'd7, 16'h5522);
    step();

    // Collision on address 9, then a non-colliding write/read pair.
    a_wr(10'd9, 16'h0F0F, 2'b11);
    step();
    a_wr(10'd9, 16'hF0F0, 2'b11);
`ifdef SRAM_BYPASS_EN
    b_rd(10'd9, 16'hF0F0);
`else
    b_rd(10'd9, 16'h0F0F);
`endif
    qcol.push_back(cyc + 1);
    step();
    a_rd(10'd9, 16'hF0F0);
    step();
    a_wr(10'd10, 16'h1111, 2'b11);
    b_rd(10'd9, 16'hF0F0);
    step();
    a_rd(10'd10, 16'h1111);
    step();

    repeat (LAT + 3) step();
    check("port A responses outstanding", qa.size(), 0);
    check("port B responses outstanding", qb.size(), 0);
    check("collisions outstanding", qcol.size(), 0);
    check("addr_err outstanding", qerr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
